di_term_router: RTL and testbench

DI_TERM_ROUTER -- requirements
Module: di_term_router

---
 rtl/di_term_router.sv | 222 ++++++++++++++++++++++
 tb/tb_di_term_router.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/di_term_router.sv
// di_term_router: routes a host device-interface transaction to one of NUM_TERMS
// terminals selected by address, and registers the terminal's response back to the host.
// The optional ready timeout (counter, TMO state, timeout_count) is built only when
// the macro DI_TIMEOUT_EN is defined. Without it the router waits in RD/WR indefinitely.
module di_term_router #(
  parameter int                      NUM_TERMS      = 4,
  parameter logic [NUM_TERMS*16-1:0] TERM_ADDRS     = {16'h0003, 16'h0002, 16'h0001, 16'h0000},
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic                      ifclk,
  input  logic                      resetb,
  // host device-interface bus
  input  logic [15:0]               di_term_addr,
  input  logic                      di_read_mode,
  input  logic                      di_write_mode,
  input  logic                      di_read,
  input  logic                      di_write,
  output logic [31:0]               di_reg_datao,
  output logic                      di_read_rdy,
  output logic                      di_write_rdy,
  output logic [15:0]               di_transfer_status,
  // terminal side
  output logic [NUM_TERMS-1:0]      t_sel,
  input  logic [NUM_TERMS*32-1:0]   t_reg_datao,
  input  logic [NUM_TERMS-1:0]      t_read_rdy,
  input  logic [NUM_TERMS-1:0]      t_write_rdy,
  input  logic [NUM_TERMS*16-1:0]   t_transfer_status,
  output logic [7:0]                timeout_count
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD       = 3'd1;
  localparam logic [2:0] ST_WR       = 3'd2;
  localparam logic [2:0] ST_UNMAP    = 3'd3;
  localparam logic [2:0] ST_CONFLICT = 3'd4;
  localparam logic [2:0] ST_TMO      = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [NUM_TERMS-1:0] tsel_q, tsel_d;
  logic [31:0]          data_d;
  logic                 rrdy_d, wrdy_d;
  logic [15:0]          stat_d;
  logic                 any_mode;
  logic                 hit;
  logic [NUM_TERMS-1:0] hit_oh;
  logic [31:0]          mux_data;
  logic                 mux_rrdy, mux_wrdy;
  logic [15:0]          mux_stat;
  logic                 tmo_hit;

  // The strobes belong to the bus but the router only acts on the mode levels.
  logic unused_strobes;
  assign unused_strobes = di_read ^ di_write;

  assign any_mode = di_read_mode | di_write_mode;
  assign t_sel    = tsel_q;

  // Address decode: the lowest matching index wins, so scan from the top down.
  always_comb begin
    hit    = 1'b0;
    hit_oh = '0;
    for (int i = NUM_TERMS - 1; i >= 0; i--) begin
      if (TERM_ADDRS[i*16 +: 16] == di_term_addr) begin
        hit       = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Response mux driven by the latched one-hot selection.
  always_comb begin
    mux_data = '0;
    mux_rrdy = 1'b0;
    mux_wrdy = 1'b0;
    mux_stat = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      if (tsel_q[i]) begin
        mux_data = mux_data | t_reg_datao[i*32 +: 32];
        mux_rrdy = mux_rrdy | t_read_rdy[i];
        mux_wrdy = mux_wrdy | t_write_rdy[i];
        mux_stat = mux_stat | t_transfer_status[i*16 +: 16];
      end
    end
  end

  // Transaction FSM; the address is only looked at while idle, and only the
  // both-modes-low condition ends a transaction.
  always_comb begin
    state_d = state_q;
    tsel_d  = tsel_q;
    case (state_q)
      ST_IDLE: begin
        tsel_d = '0;
        if (any_mode) begin
          if (di_read_mode && di_write_mode) begin
            state_d = ST_CONFLICT;
          end else if (!hit) begin
            state_d = ST_UNMAP;
          end else begin
            state_d = di_read_mode ? ST_RD : ST_WR;
            tsel_d  = hit_oh;
          end
        end
      end
      ST_RD, ST_WR: begin
        if (!any_mode) begin
          state_d = ST_IDLE;
          tsel_d  = '0;
        end else if (tmo_hit) begin
          state_d = ST_TMO;
        end
      end
      ST_UNMAP, ST_CONFLICT, ST_TMO: begin
        if (!any_mode) begin
          state_d = ST_IDLE;
          tsel_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tsel_d  = '0;
      end
    endcase
  end

  // Host response for the coming state. The entry cycle of RD/WR shows zeros
  // because the terminal only sees t_sel from that cycle on.
  always_comb begin
    data_d = '0;
    rrdy_d = 1'b0;
    wrdy_d = 1'b0;
    stat_d = '0;
    case (state_d)
      ST_RD, ST_WR: begin
        if (state_q == state_d) begin
          data_d = mux_data;
          rrdy_d = mux_rrdy;
          wrdy_d = mux_wrdy;
          stat_d = mux_stat;
        end
      end
      ST_UNMAP: begin
        data_d = 32'hAAAA_AAAA;
        rrdy_d = 1'b1;
        wrdy_d = 1'b1;
        stat_d = 16'hFFFF;
      end
      ST_CONFLICT: begin
        data_d = 32'hAAAA_AAAA;
        rrdy_d = 1'b1;
        wrdy_d = 1'b1;
        stat_d = 16'h0002;
      end
      ST_TMO: begin
        data_d = 32'hDEAD_DEAD;
        rrdy_d = 1'b1;
        wrdy_d = 1'b1;
        stat_d = 16'h0001;
      end
      default: ;
    endcase
  end

  // State, selection and registered host outputs.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q            <= ST_IDLE;
      tsel_q             <= '0;
      di_reg_datao       <= '0;
      di_read_rdy        <= 1'b0;
      di_write_rdy       <= 1'b0;
      di_transfer_status <= '0;
    end else begin
      state_q            <= state_d;
      tsel_q             <= tsel_d;
      di_reg_datao       <= data_d;
      di_read_rdy        <= rrdy_d;
      di_write_rdy       <= wrdy_d;
      di_transfer_status <= stat_d;
    end
  end

`ifdef DI_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tmo_cnt_q;
  logic        cur_rdy;

  // Count consecutive not-ready cycles of the ready that matches the mode.
  always_comb begin
    cur_rdy = (state_q == ST_RD) ? mux_rrdy : mux_wrdy;
    cnt_d   = '0;
    tmo_hit = 1'b0;
    if ((state_q == ST_RD || state_q == ST_WR) && any_mode && !cur_rdy) begin
      cnt_d   = cnt_q + 16'd1;
      tmo_hit = (cnt_d == 16'(TIMEOUT_CYCLES));
    end
  end

  // Counter and saturating timeout tally.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      cnt_q     <= '0;
      tmo_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (tmo_hit && tmo_cnt_q != 8'hFF) begin
        tmo_cnt_q <= tmo_cnt_q + 8'd1;
      end
    end
  end

  assign timeout_count = tmo_cnt_q;
`else
  // Timeout disabled: TIMEOUT_CYCLES is kept only for a common parameter list.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit            = 1'b0;
  assign timeout_count      = '0;
`endif

endmodule

// File: tb/tb_di_term_router.sv
// Bench for di_term_router: directed scenarios plus randomized transactions checked
// against a transaction-level model. Timeout expectations follow DI_TIMEOUT_EN.
module tb_di_term_router;
  localparam int NT  = 4;
  localparam int TMO = 8;

  logic              ifclk = 1'b0;
  logic              resetb = 1'b0;
  logic [15:0]       di_term_addr = '0;
  logic              di_read_mode = 1'b0, di_write_mode = 1'b0;
  logic              di_read = 1'b0, di_write = 1'b0;
  logic [31:0]       di_reg_datao;
  logic              di_read_rdy, di_write_rdy;
  logic [15:0]       di_transfer_status;
  logic [NT-1:0]     t_sel;
  logic [NT*32-1:0]  t_reg_datao;
  logic [NT-1:0]     t_read_rdy, t_write_rdy;
  logic [NT*16-1:0]  t_transfer_status;
  logic [7:0]        timeout_count;

  logic [31:0] td [NT];
  logic        trr [NT];
  logic        twr [NT];
  logic [15:0] tst [NT];

  int total = 0;
  int bad   = 0;
  int exp_tcnt = 0;

  logic [49:0] di_out;
  assign di_out = {di_read_rdy, di_write_rdy, di_transfer_status, di_reg_datao};

  localparam logic [49:0] OUT_UNMAP = {1'b1, 1'b1, 16'hFFFF, 32'hAAAA_AAAA};
  localparam logic [49:0] OUT_CONF  = {1'b1, 1'b1, 16'h0002, 32'hAAAA_AAAA};
  localparam logic [49:0] OUT_TMO   = {1'b1, 1'b1, 16'h0001, 32'hDEAD_DEAD};

  always #5 ifclk = ~ifclk;

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      t_reg_datao[i*32 +: 32]       = td[i];
      t_read_rdy[i]                 = trr[i];
      t_write_rdy[i]                = twr[i];
      t_transfer_status[i*16 +: 16] = tst[i];
    end
  end

  di_term_router #(
    .NUM_TERMS     (NT),
    .TERM_ADDRS    ({16'h0003, 16'h0002, 16'h0001, 16'h0000}),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ifclk             (ifclk),
    .resetb            (resetb),
    .di_term_addr      (di_term_addr),
    .di_read_mode      (di_read_mode),
    .di_write_mode     (di_write_mode),
    .di_read           (di_read),
    .di_write          (di_write),
    .di_reg_datao      (di_reg_datao),
    .di_read_rdy       (di_read_rdy),
    .di_write_rdy      (di_write_rdy),
    .di_transfer_status(di_transfer_status),
    .t_sel             (t_sel),
    .t_reg_datao       (t_reg_datao),
    .t_read_rdy        (t_read_rdy),
    .t_write_rdy       (t_write_rdy),
    .t_transfer_status (t_transfer_status),
    .timeout_count     (timeout_count)
  );

  // Address table of the instance is {3,2,1,0}: terminal i answers address i.
  function automatic int lookup(input logic [15:0] a);
    lookup = -1;
    for (int i = NT - 1; i >= 0; i--) if (a == 16'(i)) lookup = i;
  endfunction

  task automatic step();
    @(posedge ifclk);
    #1;
  endtask

  // Higher lowp makes terminals less likely to be ready.
  task automatic rand_terms(input int lowp);
    for (int i = 0; i < NT; i++) begin
      td[i]  = $urandom;
      tst[i] = 16'($urandom);
      trr[i] = ($urandom_range(0, 3) >= lowp);
      twr[i] = ($urandom_range(0, 3) >= lowp);
    end
  endtask

  task automatic drop_and_check(input string name);
    di_read_mode  = 1'b0;
    di_write_mode = 1'b0;
    step();
    total++;
    if (di_out !== 50'd0 || t_sel !== '0) begin
      bad++;
      $display("FAIL %s_idle: out=%h sel=%b want out=0 sel=0", name, di_out, t_sel);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NT; i++) begin
      td[i] = '0; trr[i] = 1'b0; twr[i] = 1'b0; tst[i] = '0;
    end
    #2;
    total++;
    if (di_out !== 50'd0 || t_sel !== '0 || timeout_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_state: out=%h sel=%b tcnt=%0d want all 0", di_out, t_sel, timeout_count);
    end
    step();
    step();
    resetb = 1'b1;
    step();
    total++;
    if (di_out !== 50'd0 || t_sel !== '0) begin
      bad++;
      $display("FAIL post_reset_idle: out=%h sel=%b want 0", di_out, t_sel);
    end
  endtask

  task automatic test_mapped_read();
    rand_terms(0);
    td[2] = 32'h1234_5678; trr[2] = 1'b1; twr[2] = 1'b0; tst[2] = 16'h0000;
    di_term_addr = 16'h0002;
    di_read_mode = 1'b1;
    step();
    total++;
    if (t_sel !== 4'b0100 || di_out !== 50'd0) begin
      bad++;
      $display("FAIL read_entry: sel=%b out=%h want sel=0100 out=0", t_sel, di_out);
    end
    step();
    total++;
    if (di_out !== {1'b1, 1'b0, 16'h0000, 32'h1234_5678}) begin
      bad++;
      $display("FAIL read_data: out=%h want %h", di_out, {1'b1, 1'b0, 16'h0000, 32'h1234_5678});
    end
    drop_and_check("read");
  endtask

  task automatic test_unmapped_write();
    di_term_addr  = 16'h00F0;
    di_write_mode = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if (di_out !== OUT_UNMAP || t_sel !== '0) begin
        bad++;
        $display("FAIL unmap_write: out=%h sel=%b want %h sel=0", di_out, t_sel, OUT_UNMAP);
      end
    end
    drop_and_check("unmap");
  endtask

  task automatic test_addr_latch();
    rand_terms(0);
    trr[1] = 1'b1;
    di_term_addr = 16'h0001;
    di_read_mode = 1'b1;
    step();
    di_term_addr = 16'h0003;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (t_sel !== 4'b0010 || di_out !== {trr[1], twr[1], tst[1], td[1]}) begin
        bad++;
        $display("FAIL addr_latch: sel=%b out=%h want sel=0010 out=%h", t_sel, di_out,
                 {trr[1], twr[1], tst[1], td[1]});
      end
    end
    drop_and_check("latch");
  endtask

  task automatic test_conflict();
    di_term_addr  = 16'h0002;
    di_read_mode  = 1'b1;
    di_write_mode = 1'b1;
    step();
    total++;
    if (di_out !== OUT_CONF) begin
      bad++;
      $display("FAIL conflict: out=%h want %h", di_out, OUT_CONF);
    end
    drop_and_check("conflict");
  endtask

  task automatic test_timeout();
    rand_terms(0);
    trr[1] = 1'b0; twr[1] = 1'b1;
    di_term_addr = 16'h0001;
    di_read_mode = 1'b1;
    step();
`ifdef DI_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      step();
      total++;
      if (k < TMO && di_out !== {1'b0, 1'b1, tst[1], td[1]}) begin
        bad++;
        $display("FAIL tmo_early k=%0d: out=%h want %h", k, di_out, {1'b0, 1'b1, tst[1], td[1]});
      end else if (k == TMO && (di_out !== OUT_TMO || timeout_count !== 8'(exp_tcnt + 1))) begin
        bad++;
        $display("FAIL tmo_hit: out=%h tcnt=%0d want %h tcnt=%0d", di_out, timeout_count,
                 OUT_TMO, exp_tcnt + 1);
      end
    end
    exp_tcnt++;
    trr[1] = 1'b1;
    step();
    total++;
    if (di_out !== OUT_TMO) begin
      bad++;
      $display("FAIL tmo_sticky: out=%h want %h", di_out, OUT_TMO);
    end
`else
    for (int k = 0; k < 2000; k++) begin
      step();
      total++;
      if (di_out !== {1'b0, 1'b1, tst[1], td[1]} || timeout_count !== 8'd0) begin
        bad++;
        $display("FAIL no_tmo k=%0d: out=%h tcnt=%0d want %h tcnt=0", k, di_out, timeout_count,
                 {1'b0, 1'b1, tst[1], td[1]});
      end
    end
`endif
    drop_and_check("tmo");
  endtask

  task automatic test_tmo_saturate();
`ifdef DI_TIMEOUT_EN
    trr[2] = 1'b1; twr[2] = 1'b0;
    di_term_addr = 16'h0002;
    for (int n = 0; n < 258; n++) begin
      di_write_mode = 1'b1;
      repeat (TMO + 1) step();
      exp_tcnt = (exp_tcnt < 255) ? exp_tcnt + 1 : 255;
      di_write_mode = 1'b0;
      step();
    end
    total++;
    if (timeout_count !== 8'(exp_tcnt)) begin
      bad++;
      $display("FAIL tmo_saturate: tcnt=%0d want %0d", timeout_count, exp_tcnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    rand_terms(0);
    trr[3] = 1'b1;
    di_term_addr = 16'h0003;
    di_read_mode = 1'b1;
    step();
    step();
    step();
    #2;
    resetb = 1'b0;
    exp_tcnt = 0;
    #1;
    total++;
    if (di_out !== 50'd0 || t_sel !== '0 || timeout_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_mid: out=%h sel=%b tcnt=%0d want all 0", di_out, t_sel, timeout_count);
    end
    step();
    resetb = 1'b1;
    step();
    total++;
    if (t_sel !== 4'b1000 || di_out !== 50'd0) begin
      bad++;
      $display("FAIL reset_restart: sel=%b out=%h want sel=1000 out=0", t_sel, di_out);
    end
    step();
    total++;
    if (di_out !== {trr[3], twr[3], tst[3], td[3]}) begin
      bad++;
      $display("FAIL reset_resume: out=%h want %h", di_out, {trr[3], twr[3], tst[3], td[3]});
    end
    drop_and_check("reset_mid");
  endtask

  // Random transactions; outputs follow the terminal one cycle late, with the
  // timeout rule applied to consecutive not-ready cycles.
  task automatic test_random();
    int sel, m, idx, lowp, len, lowcnt, kind;
    logic [15:0] a;
    logic [49:0] held, expo;
    logic [NT-1:0] oh;
    logic tmo, rel, tmp;
    for (int n = 0; n < 60; n++) begin
      sel  = $urandom_range(0, 5);
      a    = (sel < 4) ? 16'(sel) : (sel == 4) ? 16'h00F0 : 16'($urandom);
      m    = $urandom_range(0, 2);
      idx  = lookup(a);
      lowp = $urandom_range(0, 3);
      kind = (m == 2) ? 0 : (idx < 0) ? 1 : (m == 0) ? 2 : 3;
      oh   = '0;
      if (idx >= 0) oh[idx] = 1'b1;
      rand_terms(lowp);
      di_term_addr  = a;
      di_read_mode  = (m != 1);
      di_write_mode = (m != 0);
      step();
      expo = (kind == 0) ? OUT_CONF : (kind == 1) ? OUT_UNMAP : 50'd0;
      total++;
      if (di_out !== expo || (kind >= 2 && t_sel !== oh) || (kind == 1 && t_sel !== '0)) begin
        bad++;
        $display("FAIL rand_entry n=%0d: out=%h sel=%b want out=%h sel=%b", n, di_out, t_sel,
                 expo, oh);
      end
      len = $urandom_range(1, 20);
      lowcnt = 0;
      tmo = 1'b0;
      held = '0;
      for (int c = 0; c < len; c++) begin
        di_term_addr = 16'($urandom);
        rand_terms(lowp);
        if (kind >= 2 && !tmo) begin
          held = {trr[idx], twr[idx], tst[idx], td[idx]};
          rel  = (kind == 2) ? trr[idx] : twr[idx];
          lowcnt = rel ? 0 : lowcnt + 1;
        end
        if (m != 2 && $urandom_range(0, 7) == 0) begin
          tmp = di_read_mode;
          di_read_mode = di_write_mode;
          di_write_mode = tmp;
        end
        step();
`ifdef DI_TIMEOUT_EN
        if (kind >= 2 && !tmo && lowcnt == TMO) begin
          tmo = 1'b1;
          exp_tcnt = (exp_tcnt < 255) ? exp_tcnt + 1 : 255;
        end
`endif
        expo = (kind == 0) ? OUT_CONF : (kind == 1) ? OUT_UNMAP : tmo ? OUT_TMO : held;
        total++;
        if (di_out !== expo || timeout_count !== 8'(exp_tcnt) ||
            (kind >= 2 && !tmo && t_sel !== oh)) begin
          bad++;
          $display("FAIL rand_cycle n=%0d c=%0d: out=%h sel=%b tcnt=%0d want out=%h sel=%b tcnt=%0d",
                   n, c, di_out, t_sel, timeout_count, expo, oh, exp_tcnt);
        end
      end
      drop_and_check("rand");
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mapped_read();
    test_unmapped_write();
    test_addr_latch();
    test_conflict();
    test_timeout();
    test_tmo_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
